// File: rtl/fx_log_seq.sv
// Sequential natural-log unit: unsigned Q15.16 in, signed Q15.16 out, fixed 13-cycle latency.
// Optional macro FX_LOG_DOMAIN_CHECK_EN rejects zero/negative arguments with out_err.
module fx_log_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_err
);

    typedef enum logic [2:0] {IDLE, NORM, REFINE, FINAL, DONE} state_t;

    state_t             state, state_next;
    logic        [31:0] x, x_next;
    logic signed [31:0] y, y_next;
    logic        [2:0]  k, k_next;
    logic        [31:0] result, result_next;
    logic               err_flag, err_next;
    logic               valid_flag, valid_next;
    logic        [31:0] t;
    logic        [31:0] gap;
    logic               bad;

    function automatic logic [31:0] norm_thresh(input logic [2:0] idx);
        case (idx)
            3'd0:    return 32'h0000_8000;
            3'd1:    return 32'h0080_0000;
            3'd2:    return 32'h0800_0000;
            3'd3:    return 32'h2000_0000;
            default: return 32'h4000_0000;
        endcase
    endfunction

    function automatic logic [4:0] norm_shift(input logic [2:0] idx);
        case (idx)
            3'd0:    return 5'd16;
            3'd1:    return 5'd8;
            3'd2:    return 5'd4;
            3'd3:    return 5'd2;
            default: return 5'd1;
        endcase
    endfunction

    // ln(2^shift) in Q15.16 for each normalisation step
    function automatic logic signed [31:0] norm_const(input logic [2:0] idx);
        case (idx)
            3'd0:    return 32'sh000B_1721;
            3'd1:    return 32'sh0005_8B91;
            3'd2:    return 32'sh0002_C5C8;
            3'd3:    return 32'sh0001_62E4;
            default: return 32'sh0000_B172;
        endcase
    endfunction

    // ln(1 + 2^-idx) in Q15.16
    function automatic logic signed [31:0] refine_const(input logic [2:0] idx);
        case (idx)
            3'd1:    return 32'sh0000_67CD;
            3'd2:    return 32'sh0000_3920;
            3'd3:    return 32'sh0000_1E27;
            3'd4:    return 32'sh0000_0F85;
            3'd5:    return 32'sh0000_07E1;
            3'd6:    return 32'sh0000_03F8;
            3'd7:    return 32'sh0000_01FE;
            default: return 32'sh0000_0000;
        endcase
    endfunction

`ifdef FX_LOG_DOMAIN_CHECK_EN
    assign bad = (in_data == 32'd0) || in_data[31];
`else
    assign bad = 1'b0;
`endif

    assign t   = x + (x >> k);
    // x is normalised towards 2^31, so the residual ln(x/2^31) is about (x - 2^31)/2^31
    assign gap = 32'h8000_0000 - x;

    assign in_ready  = (state == IDLE);
    assign out_valid = valid_flag;
    assign out_data  = result;
    assign out_err   = err_flag;

    always_comb begin
        state_next  = state;
        x_next      = x;
        y_next      = y;
        k_next      = k;
        result_next = result;
        err_next    = err_flag;
        valid_next  = valid_flag;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (bad) begin
                        state_next  = DONE;
                        result_next = 32'h8000_0000;
                        err_next    = 1'b1;
                        valid_next  = 1'b1;
                    end else begin
                        state_next = NORM;
                        x_next     = in_data & 32'h7FFF_FFFF;
                        y_next     = 32'sh000A_65AF;
                        k_next     = 3'd0;
                    end
                end
            end
            NORM: begin
                if (x < norm_thresh(k)) begin
                    x_next = x << norm_shift(k);
                    y_next = y - norm_const(k);
                end
                if (k == 3'd4) begin
                    state_next = REFINE;
                    k_next     = 3'd1;
                end else begin
                    k_next = k + 3'd1;
                end
            end
            REFINE: begin
                if (!t[31]) begin
                    x_next = t;
                    y_next = y - refine_const(k);
                end
                if (k == 3'd7) begin
                    state_next = FINAL;
                    k_next     = 3'd0;
                end else begin
                    k_next = k + 3'd1;
                end
            end
            FINAL: begin
                y_next      = y - $signed(gap >> 15);
                result_next = y_next;
                err_next    = 1'b0;
                valid_next  = 1'b1;
                state_next  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= 32'd0;
            y          <= 32'sd0;
            k          <= 3'd0;
            result     <= 32'd0;
            err_flag   <= 1'b0;
            valid_flag <= 1'b0;
        end else begin
            state      <= state_next;
            x          <= x_next;
            y          <= y_next;
            k          <= k_next;
            result     <= result_next;
            err_flag   <= err_next;
            valid_flag <= valid_next;
        end
    end

endmodule

// File: tb/tb_fx_log_seq.sv
// Self-checking bench for fx_log_seq: random arguments against a loop-based log model.
module tb_fx_log_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_err;

    int checks = 0;
    int failures = 0;
    int takes = 0;

`ifdef FX_LOG_DOMAIN_CHECK_EN
    localparam bit DOM = 1'b1;
`else
    localparam bit DOM = 1'b0;
`endif

    localparam logic [31:0] NCONST [5] = '{32'h000B1721, 32'h00058B91, 32'h0002C5C8,
                                           32'h000162E4, 32'h0000B172};
    localparam logic [31:0] RCONST [7] = '{32'h000067CD, 32'h00003920, 32'h00001E27, 32'h00000F85,
                                           32'h000007E1, 32'h000003F8, 32'h000001FE};

    fx_log_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (out_valid && out_ready) takes <= takes + 1;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic bit is_bad(input logic [31:0] a);
        return DOM && (a == 32'd0 || a[31]);
    endfunction

    function automatic logic [31:0] ref_val(input logic [31:0] a);
        logic [31:0] xv, yv, tv;
        int sh;
        if (is_bad(a)) return 32'h8000_0000;
        xv = a & 32'h7FFF_FFFF;
        yv = 32'h000A65AF;
        for (int i = 0; i < 5; i++) begin
            sh = 16 >> i;
            if (xv < (32'h1 << (31 - sh))) begin
                xv = xv << sh;
                yv = yv - NCONST[i];
            end
        end
        for (int i = 1; i <= 7; i++) begin
            tv = xv + (xv >> i);
            if (!tv[31]) begin
                xv = tv;
                yv = yv - RCONST[i-1];
            end
        end
        return yv - ((32'h8000_0000 - xv) >> 15);
    endfunction

    function automatic bit near(input logic [31:0] a, input logic [31:0] b);
        int d;
        d = $signed(a - b);
        return (d >= -2) && (d <= 2);
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic send(input logic [31:0] d, output int lat, output logic [31:0] data,
                        output logic err);
        wait_ready();
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        data = out_data;
        err  = out_err;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b d=%h e=%b exp v=0 d=0 e=0", out_valid, out_data, out_err);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_unit();
        int lat; logic [31:0] d; logic e;
        send(32'h0001_0000, lat, d, e);
        checks++;
        if (lat !== 13) begin failures++; $display("FAIL unit_latency got=%0d exp=13", lat); end
        checks++;
        if (!near(d, 32'h0)) begin failures++; $display("FAIL unit_value got=%h exp=00000000+-2", d); end
        checks++;
        if (d !== ref_val(32'h0001_0000)) begin failures++; $display("FAIL unit_model got=%h exp=%h", d, ref_val(32'h0001_0000)); end
        checks++;
        if (e !== 1'b0) begin failures++; $display("FAIL unit_err got=%b exp=0", e); end
    endtask

    task automatic test_back_to_back();
        int n = 0; int gap = 0; int lat;
        logic [31:0] r1 = 32'hX, r2;
        wait_ready();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0002_0000;
        @(posedge clk); #1;
        in_data = 32'h0000_0001;
        while (gap == 0 && n < 40) begin
            if (in_ready) gap = n;
            @(posedge clk); #1;
            n++;
            if (out_valid) r1 = out_data;
        end
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        r2 = out_data;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (gap + 1 != 15) begin failures++; $display("FAIL b2b_accept_spacing got=%0d exp=15", gap + 1); end
        checks++;
        if (!near(r1, 32'h0000_B172) || r1 !== ref_val(32'h0002_0000)) begin
            failures++; $display("FAIL b2b_first got=%h exp=%h", r1, ref_val(32'h0002_0000));
        end
        checks++;
        if (!near(r2, 32'hFFF4_E8DF) || r2 !== ref_val(32'h0000_0001)) begin
            failures++; $display("FAIL b2b_second got=%h exp=%h", r2, ref_val(32'h0000_0001));
        end
        checks++;
        if (lat !== 13) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=13", lat); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d, held;
        bit stable = 1'b1, low = 1'b1;
        int n = 0; int t0;
        d = $urandom_range(32'h7FFF_FFFF, 1);
        wait_ready();
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom);
            in_data  = $urandom;
            @(posedge clk); #1;
            if (out_data !== held || out_valid !== 1'b1) stable = 1'b0;
            if (in_ready !== 1'b0) low = 1'b0;
        end
        in_valid = 1'b0;
        t0 = takes;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!stable) begin failures++; $display("FAIL bp_stable got=0 exp=1 data=%h", held); end
        checks++;
        if (!low) begin failures++; $display("FAIL bp_in_ready_low got=0 exp=1"); end
        checks++;
        if (held !== ref_val(d)) begin failures++; $display("FAIL bp_value got=%h exp=%h", held, ref_val(d)); end
        checks++;
        if (takes - t0 != 1) begin failures++; $display("FAIL bp_results got=%0d exp=1", takes - t0); end
    endtask

    task automatic test_reset_mid();
        bit quiet = 1'b1;
        int lat; logic [31:0] d; logic e;
        wait_ready();
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b0) quiet = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (!quiet) begin failures++; $display("FAIL rstmid_no_valid got=1 exp=0"); end
        send(32'h0001_0000, lat, d, e);
        checks++;
        if (lat !== 13 || !near(d, 32'h0) || e !== 1'b0) begin
            failures++; $display("FAIL rstmid_next_job lat=%0d d=%h e=%b exp lat=13 d=0 e=0", lat, d, e);
        end
    endtask

    task automatic test_domain();
        logic [31:0] args [2] = '{32'h0000_0000, 32'h8000_0000};
        int lat; logic [31:0] d; logic e;
        for (int i = 0; i < 2; i++) begin
            send(args[i], lat, d, e);
            checks++;
            if (lat !== (DOM ? 1 : 13) || d !== ref_val(args[i]) || e !== DOM) begin
                failures++;
                $display("FAIL domain_%h got lat=%0d d=%h e=%b exp lat=%0d d=%h e=%b",
                         args[i], lat, d, e, DOM ? 1 : 13, ref_val(args[i]), DOM);
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] a, d; logic e;
        for (int i = 0; i < 24; i++) begin
            a = $urandom >> $urandom_range(31, 0);
            send(a, lat, d, e);
            checks++;
            if (lat !== (is_bad(a) ? 1 : 13) || d !== ref_val(a) || e !== is_bad(a)) begin
                failures++;
                $display("FAIL random_%h got lat=%0d d=%h e=%b exp lat=%0d d=%h e=%b",
                         a, lat, d, e, is_bad(a) ? 1 : 13, ref_val(a), is_bad(a));
            end
        end
    endtask

    initial begin
        test_reset();
        test_unit();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_domain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
